// File: rtl/timebase_pkg.sv
// timebase_pkg: clock constants and the XAPP052 XNOR LFSR tap table (widths 3..64)
package timebase_pkg;
    localparam int CLK_HZ = 100_000_000;
    localparam int PIX_HZ = 25_000_000;

    function automatic logic [63:0] tap_bit(input int n);
        return n > 0 ? 64'd1 << (n - 1) : 64'd0;
    endfunction

    function automatic logic [63:0] t4(input int a, input int b, input int c, input int d);
        return tap_bit(a) | tap_bit(b) | tap_bit(c) | tap_bit(d);
    endfunction

    // Bit n-1 of the mask is set when state bit n is a feedback tap.
    function automatic logic [63:0] lfsr_taps(input int width);
        case (width)
            3:  return t4(3, 2, 0, 0);
            4:  return t4(4, 3, 0, 0);
            5:  return t4(5, 3, 0, 0);
            6:  return t4(6, 5, 0, 0);
            7:  return t4(7, 6, 0, 0);
            8:  return t4(8, 6, 5, 4);
            9:  return t4(9, 5, 0, 0);
            10: return t4(10, 7, 0, 0);
            11: return t4(11, 9, 0, 0);
            12: return t4(12, 6, 4, 1);
            13: return t4(13, 4, 3, 1);
            14: return t4(14, 5, 3, 1);
            15: return t4(15, 14, 0, 0);
            16: return t4(16, 15, 13, 4);
            17: return t4(17, 14, 0, 0);
            18: return t4(18, 11, 0, 0);
            19: return t4(19, 6, 2, 1);
            20: return t4(20, 17, 0, 0);
            21: return t4(21, 19, 0, 0);
            22: return t4(22, 21, 0, 0);
            23: return t4(23, 18, 0, 0);
            24: return t4(24, 23, 22, 17);
            25: return t4(25, 22, 0, 0);
            26: return t4(26, 6, 2, 1);
            27: return t4(27, 5, 2, 1);
            28: return t4(28, 25, 0, 0);
            29: return t4(29, 27, 0, 0);
            30: return t4(30, 6, 4, 1);
            31: return t4(31, 28, 0, 0);
            32: return t4(32, 22, 2, 1);
            33: return t4(33, 20, 0, 0);
            34: return t4(34, 27, 2, 1);
            35: return t4(35, 33, 0, 0);
            36: return t4(36, 25, 0, 0);
            37: return t4(37, 5, 4, 3) | t4(2, 1, 0, 0);
            38: return t4(38, 6, 5, 1);
            39: return t4(39, 35, 0, 0);
            40: return t4(40, 38, 21, 19);
            41: return t4(41, 38, 0, 0);
            42: return t4(42, 41, 20, 19);
            43: return t4(43, 42, 38, 37);
            44: return t4(44, 43, 18, 17);
            45: return t4(45, 44, 42, 41);
            46: return t4(46, 45, 26, 25);
            47: return t4(47, 42, 0, 0);
            48: return t4(48, 47, 21, 20);
            49: return t4(49, 40, 0, 0);
            50: return t4(50, 49, 24, 23);
            51: return t4(51, 50, 36, 35);
            52: return t4(52, 49, 0, 0);
            53: return t4(53, 52, 38, 37);
            54: return t4(54, 53, 18, 17);
            55: return t4(55, 31, 0, 0);
            56: return t4(56, 55, 35, 34);
            57: return t4(57, 50, 0, 0);
            58: return t4(58, 39, 0, 0);
            59: return t4(59, 58, 38, 37);
            60: return t4(60, 59, 0, 0);
            61: return t4(61, 60, 46, 45);
            62: return t4(62, 61, 6, 5);
            63: return t4(63, 62, 0, 0);
            64: return t4(64, 63, 61, 60);
            default: return 64'd0;
        endcase
    endfunction
endpackage

// File: rtl/timebase_rng_lfsr_core.sv
// lfsr_core: Fibonacci XNOR LFSR, state [NUM_BITS:1]; seed load beats step, all-ones is lockup.
module lfsr_core import timebase_pkg::*; #(
    parameter int NUM_BITS = 49
) (
    input  logic                in_clk,
    input  logic                reset,
    input  logic                en,
    input  logic                seed_dv,
    input  logic [NUM_BITS-1:0] seed_data,
    output logic [NUM_BITS-1:0] data,
    output logic                done
);
    localparam logic [63:0] TAP_MASK = lfsr_taps(NUM_BITS);
    logic [NUM_BITS:1] state;
    logic fb;
    assign fb = ~^(state & TAP_MASK[NUM_BITS-1:0]);
    always_ff @(posedge in_clk)
        state <= !reset ? '0 : seed_dv ? seed_data : en ? {state[NUM_BITS-1:1], fb} : state;
    assign data = state;
    assign done = state == seed_data;
endmodule

// File: rtl/timebase_rng.sv
// timebase_rng: pixel strobe, programmable slow divider and LFSR source on one clock.
// Define TIMEBASE_LFSR_EN to build the LFSR; otherwise lfsr_data/lfsr_done tie to 0.
module timebase_rng import timebase_pkg::*; #(
    parameter int PIX_DIV    = CLK_HZ / PIX_HZ,
    parameter int DIV_NUMBER = 50_000_000,
    parameter int NUM_BITS   = 49
) (
    input  logic                in_clk,
    input  logic                reset,
    input  logic                lfsr_en,
    input  logic                seed_dv,
    input  logic [NUM_BITS-1:0] seed_data,
    output logic                pix_clk,
    output logic                pix_tick,
    output logic                div_clk,
    output logic                div_tick,
    output logic [NUM_BITS-1:0] lfsr_data,
    output logic                lfsr_done
);
    localparam int PW = $clog2(PIX_DIV);
    localparam int DW = $clog2(DIV_NUMBER) + 1;
    logic [PW-1:0] pcnt;
    logic [DW-1:0] dcnt;
    logic dwrap;
    assign dwrap = dcnt == DW'(DIV_NUMBER - 1);
    always_ff @(posedge in_clk) begin
        if (!reset) begin
            pcnt     <= '0;
            dcnt     <= '0;
            div_clk  <= 1'b0;
            div_tick <= 1'b0;
        end else begin
            pcnt     <= pcnt == PW'(PIX_DIV - 1) ? '0 : pcnt + 1'b1;
            dcnt     <= dwrap ? '0 : dcnt + 1'b1;
            div_clk  <= div_clk ^ dwrap;
            div_tick <= dwrap;
        end
    end
    assign pix_clk  = pcnt >= PW'(PIX_DIV / 2);
    assign pix_tick = pcnt == PW'(PIX_DIV - 1);
`ifdef TIMEBASE_LFSR_EN
    lfsr_core #(.NUM_BITS(NUM_BITS)) u_lfsr (
        .in_clk    (in_clk),
        .reset     (reset),
        .en        (lfsr_en),
        .seed_dv   (seed_dv),
        .seed_data (seed_data),
        .data      (lfsr_data),
        .done      (lfsr_done)
    );
`else
    logic unused_lfsr;
    assign unused_lfsr = ^{lfsr_en, seed_dv, seed_data};
    assign lfsr_data   = '0;
    assign lfsr_done   = 1'b0;
`endif
endmodule

// File: tb/tb_timebase_rng.sv
// tb_timebase_rng: scoreboard bench for timebase_rng (PIX_DIV=4, DIV_NUMBER=5, NUM_BITS=3) plus a standalone lfsr_core.
module tb_timebase_rng;
    import timebase_pkg::*;

    typedef struct packed {
        logic       pc, pt, dc, dt;
        logic [2:0] ld;
        logic       lo;
        logic [2:0] cd;
        logic       co;
    } exp_t;

    logic       in_clk = 1'b0, reset = 1'b0, lfsr_en = 1'b0, seed_dv = 1'b0;
    logic [2:0] seed_data = 3'b000;
    logic       pix_clk, pix_tick, div_clk, div_tick, lfsr_done, core_done;
    logic [2:0] lfsr_data, core_data;

    exp_t sb[$];
    int n_chk = 0, n_bad = 0, k = 0, idx = 0;
    logic [2:0] seq [7] = '{3'b000, 3'b001, 3'b011, 3'b110, 3'b101, 3'b010, 3'b100};

    timebase_rng #(.PIX_DIV(4), .DIV_NUMBER(5), .NUM_BITS(3)) dut (
        .in_clk(in_clk), .reset(reset), .lfsr_en(lfsr_en), .seed_dv(seed_dv), .seed_data(seed_data),
        .pix_clk(pix_clk), .pix_tick(pix_tick), .div_clk(div_clk), .div_tick(div_tick),
        .lfsr_data(lfsr_data), .lfsr_done(lfsr_done)
    );

    lfsr_core #(.NUM_BITS(3)) core (
        .in_clk(in_clk), .reset(reset), .en(lfsr_en), .seed_dv(seed_dv), .seed_data(seed_data),
        .data(core_data), .done(core_done)
    );

    always #5 in_clk = ~in_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %0h want %0h", tag, k, got, want);
        end
    endtask

    // Drive one cycle, predict the post-edge outputs, then compare against the popped prediction.
    task automatic step(input logic r, input logic en, input logic sdv, input logic [2:0] sd);
        exp_t e, g;
        @(negedge in_clk);
        reset = r; lfsr_en = en; seed_dv = sdv; seed_data = sd;
        if (!r) begin
            k = 0;
            idx = 0;
        end else begin
            k++;
            if (sdv) begin
                for (int i = 0; i < 7; i++) if (seq[i] == sd) idx = i;
            end else if (en) begin
                idx = (idx + 1) % 7;
            end
        end
        e.pc = (k % 4) >= 2;
        e.pt = (k % 4) == 3;
        e.dt = k > 0 && (k % 5) == 0;
        e.dc = ((k / 5) % 2) == 1;
        e.cd = seq[idx];
        e.co = seq[idx] == sd;
`ifdef TIMEBASE_LFSR_EN
        e.ld = e.cd;
        e.lo = e.co;
`else
        e.ld = 3'b000;
        e.lo = 1'b0;
`endif
        sb.push_back(e);
        @(posedge in_clk);
        #1;
        g = sb.pop_front();
        chk("pix_clk", 64'(pix_clk), 64'(g.pc));
        chk("pix_tick", 64'(pix_tick), 64'(g.pt));
        chk("div_clk", 64'(div_clk), 64'(g.dc));
        chk("div_tick", 64'(div_tick), 64'(g.dt));
        chk("lfsr_data", 64'(lfsr_data), 64'(g.ld));
        chk("lfsr_done", 64'(lfsr_done), 64'(g.lo));
        chk("core_data", 64'(core_data), 64'(g.cd));
        chk("core_done", 64'(core_done), 64'(g.co));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        chk("taps3", lfsr_taps(3), 64'h6);
        chk("taps8", lfsr_taps(8), 64'hB8);
        chk("taps49", lfsr_taps(49), (64'd1 << 48) | (64'd1 << 39));
        repeat (3) step(1'b0, 1'b0, 1'b0, 3'b000);
        repeat (18) step(1'b1, 1'b1, 1'b0, 3'b000);
        step(1'b0, 1'b1, 1'b0, 3'b000);
        step(1'b1, 1'b0, 1'b1, 3'b011);
        step(1'b1, 1'b1, 1'b0, 3'b011);
        for (int i = 0; i < 40; i++)
            step(1'b1, 1'($urandom_range(1)), $urandom_range(7) == 0, seq[$urandom_range(6)]);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
